// File: rtl/if_id_fetch_stage.sv
// Instruction fetch stage and IF/ID pipeline register for the 16-bit core.
// Owns the PC, runs the imem req/ack handshake and splits the latched word into fields.
module if_id_fetch_stage #(
  parameter int unsigned      DataW   = 16,
  parameter logic [DataW-1:0] ResetPc = '0,
  parameter int unsigned      PcInc   = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic             imem_req_o,
  output logic [DataW-1:0] imem_addr_o,
  input  logic             imem_ack_i,
  input  logic [DataW-1:0] imem_rdata_i,
  input  logic             stall_i,
  input  logic             branch_taken_i,
  input  logic [DataW-1:0] branch_target_i,
  output logic             id_valid_o,
  output logic [DataW-1:0] id_instr_o,
  output logic [DataW-1:0] id_pc_plus1_o,
  output logic [3:0]       id_opcode_o,
  output logic [1:0]       id_rt_o,
  output logic [1:0]       id_rs_o,
  output logic [7:0]       id_imm8_o
);

  typedef enum logic [1:0] {StFetch, StHold, StKill} state_e;

  state_e           state_q, state_d;
  logic [DataW-1:0] pc_q, pc_d;
  logic [DataW-1:0] kill_addr_q, kill_addr_d;
  logic [DataW-1:0] skid_instr_q, skid_instr_d;
  logic [DataW-1:0] skid_pcp1_q, skid_pcp1_d;
  logic             id_valid_q, id_valid_d;
  logic [DataW-1:0] id_instr_q, id_instr_d;
  logic [DataW-1:0] id_pcp1_q, id_pcp1_d;

  logic             accept;
  logic             req;
  logic [DataW-1:0] addr;
  logic [DataW-1:0] pc_next;

  assign pc_next = pc_q + DataW'(PcInc);
  assign accept  = !id_valid_q || !stall_i;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_addr_d  = kill_addr_q;
    skid_instr_d = skid_instr_q;
    skid_pcp1_d  = skid_pcp1_q;
    id_valid_d   = id_valid_q;
    id_instr_d   = id_instr_q;
    id_pcp1_d    = id_pcp1_q;
    req          = 1'b0;
    addr         = pc_q;

    // Decode consumed the current word and nothing new arrives: insert a NOP bubble.
    if (accept) begin
      id_valid_d = 1'b0;
      id_instr_d = '0;
    end

    case (state_q)
      StFetch: begin
        req  = 1'b1;
        addr = pc_q;
        if (branch_taken_i) begin
          pc_d = branch_target_i;
          if (!imem_ack_i) begin
            kill_addr_d = pc_q;
            state_d     = StKill;
          end
        end else if (imem_ack_i) begin
          pc_d = pc_next;
          if (accept) begin
            id_valid_d = 1'b1;
            id_instr_d = imem_rdata_i;
            id_pcp1_d  = pc_next;
          end else begin
            skid_instr_d = imem_rdata_i;
            skid_pcp1_d  = pc_next;
            state_d      = StHold;
          end
        end
      end
      StHold: begin
        if (branch_taken_i) begin
          pc_d    = branch_target_i;
          state_d = StFetch;
        end else if (accept) begin
          id_valid_d = 1'b1;
          id_instr_d = skid_instr_q;
          id_pcp1_d  = skid_pcp1_q;
          state_d    = StFetch;
        end
      end
      StKill: begin
        // Finish the abandoned request at its original address, then drop the data.
        req  = 1'b1;
        addr = kill_addr_q;
        if (branch_taken_i) begin
          pc_d = branch_target_i;
        end
        if (imem_ack_i) begin
          state_d = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase

    if (branch_taken_i) begin
      id_valid_d   = 1'b0;
      id_instr_d   = '0;
      skid_instr_d = '0;
      skid_pcp1_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StFetch;
      pc_q         <= ResetPc;
      kill_addr_q  <= ResetPc;
      skid_instr_q <= '0;
      skid_pcp1_q  <= '0;
      id_valid_q   <= 1'b0;
      id_instr_q   <= '0;
      id_pcp1_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_addr_q  <= kill_addr_d;
      skid_instr_q <= skid_instr_d;
      skid_pcp1_q  <= skid_pcp1_d;
      id_valid_q   <= id_valid_d;
      id_instr_q   <= id_instr_d;
      id_pcp1_q    <= id_pcp1_d;
    end
  end

  // Outputs are forced quiet during the reset cycle itself, before the registers clear.
  assign imem_req_o    = req && !rst_i;
  assign imem_addr_o   = rst_i ? ResetPc : addr;
  assign id_valid_o    = id_valid_q && !rst_i;
  assign id_instr_o    = rst_i ? '0 : id_instr_q;
  assign id_pc_plus1_o = rst_i ? '0 : id_pcp1_q;

  assign id_opcode_o = id_instr_o[15:12];
  assign id_rt_o     = id_instr_o[11:10];
  assign id_rs_o     = id_instr_o[9:8];
  assign id_imm8_o   = id_instr_o[7:0];

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Directed bench for if_id_fetch_stage: per-cycle vector table plus a stall/bubble sequence.
// Memory model returns addr ^ 16'h3A9C and acks after a programmable wait count.
module tb_if_id_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        id_valid;
  logic [15:0] id_instr;
  logic [15:0] id_pc_plus1;
  logic [3:0]  id_opcode;
  logic [1:0]  id_rt;
  logic [1:0]  id_rs;
  logic [7:0]  id_imm8;

  int lat;
  int cnt;
  int n_total;
  int n_pass;

  if_id_fetch_stage dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .imem_req_o     (imem_req),
    .imem_addr_o    (imem_addr),
    .imem_ack_i     (imem_ack),
    .imem_rdata_i   (imem_rdata),
    .stall_i        (stall),
    .branch_taken_i (branch_taken),
    .branch_target_i(branch_target),
    .id_valid_o     (id_valid),
    .id_instr_o     (id_instr),
    .id_pc_plus1_o  (id_pc_plus1),
    .id_opcode_o    (id_opcode),
    .id_rt_o        (id_rt),
    .id_rs_o        (id_rs),
    .id_imm8_o      (id_imm8)
  );

  always #5 clk = ~clk;

  assign imem_ack   = imem_req && (cnt >= lat);
  assign imem_rdata = imem_addr ^ 16'h3A9C;

  always @(posedge clk) begin
    if (imem_req && !imem_ack) cnt <= cnt + 1;
    else                       cnt <= 0;
  end

  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic [15:0] tgt;
    int          lat;
    logic        req;
    logic [15:0] addr;
    logic        chk_addr;
    logic        valid;
    logic [15:0] instr;
    logic [15:0] pcp1;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic s, input logic b, input logic [15:0] t,
                     input int l, input logic q, input logic [15:0] a, input logic ca,
                     input logic v, input logic [15:0] ins, input logic [15:0] p);
    vec_t e;
    e.rst = r; e.stall = s; e.br = b; e.tgt = t; e.lat = l;
    e.req = q; e.addr = a; e.chk_addr = ca; e.valid = v; e.instr = ins; e.pcp1 = p;
    vecs.push_back(e);
  endtask

  task automatic check(input string name, input int row, input logic [15:0] act,
                       input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
  endtask

  task automatic check_all(input int row, input vec_t e);
    check("imem_req", row, {15'd0, imem_req}, {15'd0, e.req});
    if (e.chk_addr) check("imem_addr", row, imem_addr, e.addr);
    check("id_valid", row, {15'd0, id_valid}, {15'd0, e.valid});
    check("id_instr", row, id_instr, e.instr);
    check("id_pc_plus1", row, id_pc_plus1, e.pcp1);
    check("id_fields", row, {id_opcode, id_rt, id_rs, id_imm8}, e.instr);
  endtask

  initial begin
    vec_t h;
    n_total = 0; n_pass = 0;
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0; lat = 0;

    //  rst stall br tgt      lat | req addr     chk valid instr     pcp1
    add(1, 0, 0, 16'h0000, 0,  0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    add(1, 0, 0, 16'h0000, 0,  0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    add(0, 0, 0, 16'h0000, 0,  1, 16'h0000, 1, 0, 16'h0000, 16'h0000);
    add(0, 0, 0, 16'h0000, 0,  1, 16'h0001, 1, 1, 16'h3A9C, 16'h0001);
    add(0, 0, 0, 16'h0000, 0,  1, 16'h0002, 1, 1, 16'h3A9D, 16'h0002);
    add(0, 0, 0, 16'h0000, 0,  1, 16'h0003, 1, 1, 16'h3A9E, 16'h0003);
    // latency 3: address held 4 cycles, one-cycle valid pulses
    add(0, 0, 0, 16'h0000, 3,  1, 16'h0004, 1, 1, 16'h3A9F, 16'h0004);
    add(0, 0, 0, 16'h0000, 3,  1, 16'h0004, 1, 0, 16'h0000, 16'h0004);
    add(0, 0, 0, 16'h0000, 3,  1, 16'h0004, 1, 0, 16'h0000, 16'h0004);
    add(0, 0, 0, 16'h0000, 3,  1, 16'h0004, 1, 0, 16'h0000, 16'h0004);
    add(0, 0, 0, 16'h0000, 3,  1, 16'h0005, 1, 1, 16'h3A98, 16'h0005);
    add(0, 0, 0, 16'h0000, 3,  1, 16'h0005, 1, 0, 16'h0000, 16'h0005);
    add(0, 0, 0, 16'h0000, 3,  1, 16'h0005, 1, 0, 16'h0000, 16'h0005);
    add(0, 0, 0, 16'h0000, 3,  1, 16'h0005, 1, 0, 16'h0000, 16'h0005);
    // stall with valid word while ack arrives -> HOLD, then release
    add(0, 1, 0, 16'h0000, 0,  1, 16'h0006, 1, 1, 16'h3A99, 16'h0006);
    add(0, 1, 0, 16'h0000, 0,  0, 16'h0000, 0, 1, 16'h3A99, 16'h0006);
    add(0, 0, 0, 16'h0000, 0,  0, 16'h0000, 0, 1, 16'h3A99, 16'h0006);
    add(0, 0, 0, 16'h0000, 0,  1, 16'h0007, 1, 1, 16'h3A9A, 16'h0007);
    // branch in FETCH without ack, latency 3 -> KILL holds old address
    add(0, 0, 1, 16'h0040, 3,  1, 16'h0008, 1, 1, 16'h3A9B, 16'h0008);
    add(0, 0, 0, 16'h0000, 3,  1, 16'h0008, 1, 0, 16'h0000, 16'h0008);
    add(0, 0, 0, 16'h0000, 3,  1, 16'h0008, 1, 0, 16'h0000, 16'h0008);
    add(0, 0, 0, 16'h0000, 3,  1, 16'h0008, 1, 0, 16'h0000, 16'h0008);
    // branch + stall + ack in the same cycle
    add(0, 1, 1, 16'h0080, 0,  1, 16'h0040, 1, 0, 16'h0000, 16'h0008);
    add(0, 0, 0, 16'h0000, 0,  1, 16'h0080, 1, 0, 16'h0000, 16'h0008);
    // branch + stall with a live word, no ack
    add(0, 1, 1, 16'h0010, 1,  1, 16'h0081, 1, 1, 16'h3A1C, 16'h0081);
    add(0, 0, 0, 16'h0000, 1,  1, 16'h0081, 1, 0, 16'h0000, 16'h0081);
    add(0, 0, 0, 16'h0000, 0,  1, 16'h0010, 1, 0, 16'h0000, 16'h0081);
    // wrap at 16'hFFFF
    add(0, 0, 1, 16'hFFFF, 0,  1, 16'h0011, 1, 1, 16'h3A8C, 16'h0011);
    add(0, 0, 0, 16'h0000, 0,  1, 16'hFFFF, 1, 0, 16'h0000, 16'h0011);
    add(0, 0, 0, 16'h0000, 0,  1, 16'h0000, 1, 1, 16'hC563, 16'h0000);
    // reset while a request is pending
    add(0, 0, 0, 16'h0000, 3,  1, 16'h0001, 1, 1, 16'h3A9C, 16'h0001);
    add(1, 0, 0, 16'h0000, 3,  0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    add(0, 0, 0, 16'h0000, 0,  1, 16'h0000, 1, 0, 16'h0000, 16'h0000);
    add(0, 0, 0, 16'h0000, 0,  1, 16'h0001, 1, 1, 16'h3A9C, 16'h0001);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; stall = vecs[i].stall; branch_taken = vecs[i].br;
      branch_target = vecs[i].tgt; lat = vecs[i].lat;
      @(negedge clk);
      check_all(i, vecs[i]);
      @(posedge clk); #1;
    end

    // Bubble is filled under stall when IF/ID is empty; next ack under stall goes to HOLD.
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; lat = 0;
    @(posedge clk); #1;
    rst = 1'b0; stall = 1'b1;
    h.req = 1; h.addr = 16'h0000; h.chk_addr = 1; h.valid = 0; h.instr = 16'h0000;
    h.pcp1 = 16'h0000;
    @(negedge clk); check_all(100, h);
    @(posedge clk); #1;
    h.addr = 16'h0001; h.valid = 1; h.instr = 16'h3A9C; h.pcp1 = 16'h0001;
    @(negedge clk); check_all(101, h);
    @(posedge clk); #1;
    h.req = 0; h.chk_addr = 0;
    @(negedge clk); check_all(102, h);
    @(posedge clk); #1;
    stall = 1'b0;
    @(negedge clk); check_all(103, h);
    @(posedge clk); #1;
    h.req = 1; h.chk_addr = 1; h.addr = 16'h0002; h.instr = 16'h3A9D; h.pcp1 = 16'h0002;
    @(negedge clk); check_all(104, h);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
